tc_pl_cap_pack: RTL and testbench
=================================

# tc_pl_cap_pack

- Parametrised capture-to-memory mover sitting between the merged ADC capture path (Gc_*) and the ACP write port (acp0_*).
- Per capture request it walks a channel mask; for each enabled gain channel it:
  - triggers one acquisition,
  - accepts a programmable number of merged samples,
  - packs each sample into a 64-bit word,
  - writes the words as bursts to a contiguous memory region.
- It signals completion and, optionally, a CRC32 of everything written.

## Interface
Parameters:
- DATA_W, 56, merged sample width (must be ≤ 64)
- NCH, 4, number of gain channels (1–8)
- PTS_W, 14, width of per-channel point count
- BURST, 16, maximum beats per ACP burst (power of two, ≤ 256)
- FIFO_DEPTH, 32, packing FIFO depth in 64-bit words (≥ BURST, power of two)

Ports (one clock; reset is asynchronous and active-high):
- clk125  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- data_en  in  1  capture start pulse
- data_cmpt  out  1  one-cycle completion pulse
- cap_busy  out  1  high from accepted start until data_cmpt
- cap_err  out  1  sticky: start rejected (zero points or zero mask); cleared by next accepted start
- cap_points  in  PTS_W  samples per channel
- cap_ch_mask  in  NCH  enabled channels
- cap_addr  in  32  destination base byte address (bits [2:0] ignored)
- cap_crc32  out  32  CRC of written data
- Gc_cap_trig  out  1  one-cycle acquisition trigger
- Gc_capr_rdy  in  1  capture front-end ready for trigger
- Gc_merge_data  in  DATA_W  merged sample
- Gc_mereg_datv  in  1  sample valid
- Gc_mereg_datr  out  1  sample ready
- acp0_tx_en  out  1  burst request
- acp0_tx_rdy  in  1  burst request accepted
- acp0_tx_awaddr  out  32  burst byte address
- acp0_tx_awid  out  3  channel index of burst
- acp0_tx_awlen  out  8  beats minus one
- acp0_tx_wdata  out  64  write data
- acp0_tx_wdreq  in  1  sink requests next beat

## Operation
- Capture FSM states: IDLE, ARM, RECV, FLUSH, DONE.
- **IDLE:**
  - data_en with cap_points ≠ 0 and cap_ch_mask ≠ 0:
    - latch points, mask and address;
    - clear cap_err and CRC;
    - select the lowest set mask bit;
    - go to ARM.
  - data_en with cap_points = 0 or mask = 0:
    - set cap_err;
    - pulse data_cmpt the next cycle;
    - no trigger is issued.
  - data_en is ignored while cap_busy is high.
- **ARM:** wait for Gc_capr_rdy; pulse Gc_cap_trig for one cycle; go to RECV.
- **RECV:**
  - Gc_mereg_datr = FIFO not full.
  - A sample is accepted when datv && datr.
  - Word format:
    - {sample_index[63−DATA_W:0], sample}, where sample_index counts 0..points−1;
    - when DATA_W = 64 there are no index bits.
  - After the last sample, go to FLUSH.
- **FLUSH:**
  - wait until the FIFO is empty and the write FSM is idle;
  - if a higher mask bit is set, select it and go to ARM; else go to DONE.
- **DONE:** pulse data_cmpt; return to IDLE.
- Write FSM states: W_IDLE, W_ADDR, W_DATA.
  - **W_IDLE → W_ADDR** when FIFO count ≥ BURST, or when in FLUSH with count > 0.
    - Burst length = min(BURST, count); awlen = length−1.
    - awid = current channel index.
  - **W_ADDR:** assert acp0_tx_en with stable awaddr/awid/awlen until acp0_tx_rdy is sampled high, then go to W_DATA.
  - **W_DATA:** each cycle wdreq is high pops one word. After length pops, go to W_IDLE.
  - The running address advances by 8 per beat, contiguous across channels.
- Bursts never mix channels: the next channel is not armed until the FIFO has drained.

## Timing
- Reset values: all outputs 0; FSMs in IDLE/W_IDLE; FIFO empty; CRC register 0xFFFFFFFF internally.
- Gc_cap_trig asserts the cycle after Gc_capr_rdy is seen high in ARM.
- Sample to FIFO: 1 cycle.
- acp0_tx_wdata updates on the edge where wdreq is high; the sink samples it the following cycle.
- wdreq with the FIFO empty is a protocol violation; wdata holds its value.
- Simultaneous FIFO push and pop: count unchanged.
- A full FIFO deasserts datr in the same cycle.
- data_cmpt asserts one cycle after the final beat pop plus FLUSH detection; worst case 2 cycles after the last pop.
- Address arithmetic is 32-bit modulo with wrap and no boundary splitting. Software keeps regions below 4 GB.
- rst mid-operation aborts immediately:
  - FIFO is discarded;
  - no data_cmpt is issued;
  - an in-flight ACP burst is truncated.

## Configuration
- TC_CAP_CRC_EN defined:
  - CRC32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final XOR 0xFFFFFFFF) is computed over every popped 64-bit word, little-endian byte order;
  - cap_crc32 is updated when data_cmpt asserts and holds until the next accepted start.
- Undefined: cap_crc32 is tied to 0 and no CRC logic is present.

## Structure
- Shared package tc_pl_cap_pkg:
  - capture FSM and write FSM state enums;
  - CRC polynomial/init constants;
  - the function computing CRC32 over 64 bits.
- Sub-module tc_pl_cap_fifo: synchronous show-ahead FIFO with count output, parameter FIFO_DEPTH, using the same clk125/rst.

## Test plan
- points=20, mask=4'b0001, BURST=16, addr=0x1000_0000:
  - one trigger;
  - bursts at 0x1000_0000 (awlen 15) and 0x1000_0080 (awlen 3), awid 0;
  - data_cmpt once.
- points=16, mask=4'b1010:
  - two triggers;
  - awid 1 at base, then awid 3 at base+0x80;
  - upper word bits carry indices 0..15 per channel.
- Hold Gc_capr_rdy low 50 cycles in ARM: no trigger until it rises, then exactly one trig pulse.
- points=64, FIFO_DEPTH=32, wdreq held low 200 cycles:
  - datr drops once 32 words are buffered;
  - no sample is lost or duplicated after wdreq resumes.
- data_en with points=0:
  - cap_err=1;
  - data_cmpt pulses the next cycle;
  - no Gc_cap_trig.
- Assert rst in the middle of RECV:
  - all outputs return to 0 the same cycle;
  - a following start with points=4 completes normally.
- With TC_CAP_CRC_EN: cap_crc32 matches the bench model CRC of all words written.

Source files
------------

// File: rtl/tc_pl_cap_pkg.sv
// tc_pl_cap_pkg: FSM state types, CRC32 constants and the 64-bit CRC32 step
// shared by the capture-to-memory mover.
package tc_pl_cap_pkg;
    typedef enum logic [2:0] {IDLE, ARM, RECV, FLUSH, DONE} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_state_t;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    // Reflected CRC32 over one word, bit 0 first (little-endian byte order).
    function automatic logic [31:0] crc32_64(input logic [31:0] crc, input logic [63:0] d);
        logic [31:0] c, p;
        c = crc;
        for (int i = 0; i < 32; i++) p[i] = CRC_POLY[31-i];
        for (int i = 0; i < 64; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? p : 32'h0);
        return c;
    endfunction
endpackage

// File: rtl/tc_pl_cap_fifo.sv
// tc_pl_cap_fifo: synchronous show-ahead FIFO with occupancy count.
module tc_pl_cap_fifo #(
    parameter int FIFO_DEPTH = 32,
    parameter int W = 64
) (
    input  logic                        clk125,
    input  logic                        rst,
    input  logic                        push,
    input  logic [W-1:0]                din,
    input  logic                        pop,
    output logic [W-1:0]                dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == CW'(FIFO_DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk125)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/tc_pl_cap_pack.sv
// tc_pl_cap_pack: walks a channel mask, captures merged samples per channel and bursts
// them as 64-bit words to the ACP port; TC_CAP_CRC_EN adds a CRC32 of all written words.
module tc_pl_cap_pack
    import tc_pl_cap_pkg::*;
#(
    parameter int DATA_W = 56,
    parameter int NCH = 4,
    parameter int PTS_W = 14,
    parameter int BURST = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic              data_en,
    output logic              data_cmpt,
    output logic              cap_busy,
    output logic              cap_err,
    input  logic [PTS_W-1:0]  cap_points,
    input  logic [NCH-1:0]    cap_ch_mask,
    input  logic [31:0]       cap_addr,
    output logic [31:0]       cap_crc32,
    output logic              Gc_cap_trig,
    input  logic              Gc_capr_rdy,
    input  logic [DATA_W-1:0] Gc_merge_data,
    input  logic              Gc_mereg_datv,
    output logic              Gc_mereg_datr,
    output logic              acp0_tx_en,
    input  logic              acp0_tx_rdy,
    output logic [31:0]       acp0_tx_awaddr,
    output logic [2:0]        acp0_tx_awid,
    output logic [7:0]        acp0_tx_awlen,
    output logic [63:0]       acp0_tx_wdata,
    input  logic              acp0_tx_wdreq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    cap_state_t state, state_nxt;
    wr_state_t wstate, wstate_nxt;
    logic [PTS_W-1:0] points, idx;
    logic [NCH-1:0] pend, src, pend_nxt;
    logic [2:0] ch, low_ch;
    logic [31:0] addr;
    logic [7:0] beat;
    logic [CW-1:0] count;
    logic [63:0] word, head;
    logic full, empty, rej, start_ok, start_bad, accept, last_smp, pop, flush_done, next_ch, burst_go;
    assign start_ok = state == IDLE && data_en && cap_points != '0 && cap_ch_mask != '0;
    assign start_bad = state == IDLE && data_en && (cap_points == '0 || cap_ch_mask == '0);
    assign Gc_mereg_datr = state == RECV && !full;
    assign accept = Gc_mereg_datv && Gc_mereg_datr;
    assign last_smp = accept && idx == points - 1'b1;
    // Index bits fall off the top naturally when DATA_W leaves no room.
    assign word = 64'(Gc_merge_data) | (64'(idx) << DATA_W);
    assign pop = wstate == W_DATA && acp0_tx_wdreq && !empty;
    assign flush_done = state == FLUSH && empty && wstate == W_IDLE;
    assign next_ch = flush_done && pend != '0;
    assign burst_go = wstate == W_IDLE && (int'(count) >= BURST || (state == FLUSH && count != '0));
    assign src = state == IDLE ? cap_ch_mask : pend;
    assign pend_nxt = src & (src - 1'b1);
    always_comb begin
        low_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) if (src[i]) low_ch = 3'(i);
    end
    assign cap_busy = state != IDLE;
    assign data_cmpt = state == DONE || rej;
    assign acp0_tx_en = wstate == W_ADDR;
    assign acp0_tx_awaddr = addr;
    assign acp0_tx_awid = ch;

    tc_pl_cap_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
        .clk125(clk125), .rst(rst), .push(accept), .din(word), .pop(pop),
        .dout(head), .count(count), .full(full), .empty(empty)
    );

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wstate <= W_IDLE;
        end else begin
            state <= state_nxt;
            wstate <= wstate_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_ok ? ARM : IDLE;
            ARM:     state_nxt = Gc_capr_rdy ? RECV : ARM;
            RECV:    state_nxt = last_smp ? FLUSH : RECV;
            FLUSH:   state_nxt = flush_done ? (next_ch ? ARM : DONE) : FLUSH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  wstate_nxt = burst_go ? W_ADDR : W_IDLE;
            W_ADDR:  wstate_nxt = acp0_tx_rdy ? W_DATA : W_ADDR;
            W_DATA:  wstate_nxt = (pop && beat == acp0_tx_awlen) ? W_IDLE : W_DATA;
            default: wstate_nxt = W_IDLE;
        endcase
    end
    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            points <= '0;
            idx <= '0;
            pend <= '0;
            ch <= '0;
            addr <= '0;
            beat <= '0;
            rej <= 1'b0;
            cap_err <= 1'b0;
            Gc_cap_trig <= 1'b0;
            acp0_tx_awlen <= '0;
            acp0_tx_wdata <= '0;
        end else begin
            Gc_cap_trig <= state == ARM && Gc_capr_rdy;
            rej <= start_bad;
            if (start_bad) cap_err <= 1'b1;
            if (start_ok) begin
                cap_err <= 1'b0;
                points <= cap_points;
                addr <= cap_addr & 32'hFFFF_FFF8;
            end
            if (start_ok || next_ch) begin
                ch <= low_ch;
                pend <= pend_nxt;
                idx <= '0;
            end
            if (accept) idx <= idx + 1'b1;
            if (burst_go) begin
                acp0_tx_awlen <= 8'((int'(count) < BURST ? int'(count) : BURST) - 1);
                beat <= '0;
            end
            if (pop) begin
                beat <= beat + 1'b1;
                addr <= addr + 32'd8;
                acp0_tx_wdata <= head;
            end
        end
    end

`ifdef TC_CAP_CRC_EN
    logic [31:0] crc, crc_out;
    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
            crc_out <= '0;
        end else begin
            if (start_ok) begin
                crc <= CRC_INIT;
                crc_out <= '0;
            end else if (pop) crc <= crc32_64(crc, head);
            if (flush_done && !next_ch) crc_out <= ~crc;
        end
    end
    assign cap_crc32 = crc_out;
`else
    assign cap_crc32 = '0;
`endif
endmodule

// File: tb/tb_tc_pl_cap_pack.sv
// tb_tc_pl_cap_pack: scoreboard bench for tc_pl_cap_pack with a random-valid
// capture source and a random-ready ACP sink.
module tb_tc_pl_cap_pack;
    localparam int DATA_W = 56;
    localparam int NCH = 4;
    localparam int PTS_W = 14;
    localparam int BURST = 16;
    localparam int FIFO_DEPTH = 32;

    typedef struct {
        logic [63:0] word;
        int          ch;
    } ent_t;

    logic clk125, rst, data_en, data_cmpt, cap_busy, cap_err;
    logic [PTS_W-1:0] cap_points;
    logic [NCH-1:0] cap_ch_mask;
    logic [31:0] cap_addr, cap_crc32;
    logic Gc_cap_trig, Gc_capr_rdy, Gc_mereg_datv, Gc_mereg_datr;
    logic [DATA_W-1:0] Gc_merge_data;
    logic acp0_tx_en, acp0_tx_rdy, acp0_tx_wdreq;
    logic [31:0] acp0_tx_awaddr;
    logic [2:0] acp0_tx_awid;
    logic [7:0] acp0_tx_awlen;
    logic [63:0] acp0_tx_wdata;

    int n_cmp = 0, n_bad = 0;
    ent_t exp_q[$];
    int chq[$];
    logic [31:0] hdr_addr_q[$];
    logic [7:0] hdr_len_q[$];
    int hdr_id_q[$];
    int model_pts = 0, smp_idx = 0, cur_ch = 0, acc_cnt = 0, trig_cnt = 0, cmpt_cnt = 0;
    int trig0 = 0, cmpt0 = 0, acc0 = 0, req_left = 0, s_st = 0;
    bit src_on = 0, acc_pending = 0, beat_pending = 0, sink_hold = 0;
    logic [31:0] exp_addr = '0, crc_m = '1;

    tc_pl_cap_pack #(.DATA_W(DATA_W), .NCH(NCH), .PTS_W(PTS_W), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk125(clk125), .rst(rst), .data_en(data_en), .data_cmpt(data_cmpt), .cap_busy(cap_busy),
        .cap_err(cap_err), .cap_points(cap_points), .cap_ch_mask(cap_ch_mask), .cap_addr(cap_addr),
        .cap_crc32(cap_crc32), .Gc_cap_trig(Gc_cap_trig), .Gc_capr_rdy(Gc_capr_rdy),
        .Gc_merge_data(Gc_merge_data), .Gc_mereg_datv(Gc_mereg_datv), .Gc_mereg_datr(Gc_mereg_datr),
        .acp0_tx_en(acp0_tx_en), .acp0_tx_rdy(acp0_tx_rdy), .acp0_tx_awaddr(acp0_tx_awaddr),
        .acp0_tx_awid(acp0_tx_awid), .acp0_tx_awlen(acp0_tx_awlen), .acp0_tx_wdata(acp0_tx_wdata),
        .acp0_tx_wdreq(acp0_tx_wdreq)
    );

    initial begin
        clk125 = 0;
        forever #4 clk125 = ~clk125;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [63:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            r ^= 32'(w[8*b +: 8]);
            for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB8_8320 : r >> 1;
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk125);
        #1;
    endtask

    // Event counters.
    initial forever begin
        @(negedge clk125);
        if (Gc_cap_trig) trig_cnt++;
        if (data_cmpt) cmpt_cnt++;
    end

    // Capture source: expected words are queued as each sample is handed over.
    initial begin
        Gc_mereg_datv = 0;
        Gc_merge_data = '0;
        forever begin
            @(negedge clk125);
            if (acc_pending) begin
                exp_q.push_back('{word: 64'(Gc_merge_data) | (64'(smp_idx) << DATA_W), ch: cur_ch});
                smp_idx++;
                acc_cnt++;
                Gc_merge_data = DATA_W'({$urandom(), $urandom()});
                if (smp_idx == model_pts) src_on = 0;
            end
            if (Gc_cap_trig) begin
                cur_ch = chq.size() != 0 ? chq.pop_front() : 7;
                smp_idx = 0;
                src_on = 1;
            end
            Gc_mereg_datv = src_on && ($urandom_range(0, 3) != 0);
            acc_pending = Gc_mereg_datv && Gc_mereg_datr;
        end
    end

    // ACP sink: checks headers, requests beats and compares popped words.
    initial begin
        acp0_tx_rdy = 0;
        acp0_tx_wdreq = 0;
        forever begin
            @(negedge clk125);
            if (beat_pending) begin
                if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
                else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("wdata", acp0_tx_wdata, e.word);
                    crc_m = crc_upd(crc_m, acp0_tx_wdata);
                    exp_addr += 32'd8;
                end
                beat_pending = 0;
            end
            acp0_tx_rdy = 0;
            acp0_tx_wdreq = 0;
            if (s_st == 0) begin
                if (acp0_tx_en && $urandom_range(0, 2) != 0) begin
                    chk("awaddr", acp0_tx_awaddr, exp_addr);
                    chk("awid", acp0_tx_awid, exp_q.size() != 0 ? exp_q[0].ch : 8);
                    chk("awlen_ok", int'(acp0_tx_awlen) < BURST && int'(acp0_tx_awlen) < exp_q.size(), 1);
                    hdr_addr_q.push_back(acp0_tx_awaddr);
                    hdr_len_q.push_back(acp0_tx_awlen);
                    hdr_id_q.push_back(int'(acp0_tx_awid));
                    req_left = int'(acp0_tx_awlen) + 1;
                    acp0_tx_rdy = 1;
                    s_st = 1;
                end
            end else if (req_left > 0) begin
                if (!sink_hold && $urandom_range(0, 3) != 0) begin
                    acp0_tx_wdreq = 1;
                    req_left--;
                    beat_pending = 1;
                end
            end else if (!beat_pending) s_st = 0;
        end
    end

    task automatic start_cap(input int pts, input logic [3:0] mask, input logic [31:0] a);
        tick();
        model_pts = pts;
        chq.delete();
        for (int i = 0; i < NCH; i++) if (mask[i]) chq.push_back(i);
        exp_addr = a & 32'hFFFF_FFF8;
        crc_m = '1;
        hdr_addr_q.delete();
        hdr_len_q.delete();
        hdr_id_q.delete();
        trig0 = trig_cnt;
        cmpt0 = cmpt_cnt;
        acc0 = acc_cnt;
        cap_points = PTS_W'(pts);
        cap_ch_mask = mask;
        cap_addr = a;
        data_en = 1;
        tick();
        data_en = 0;
        chk("start_busy", cap_busy, 1);
    endtask

    task automatic wait_cmpt(input string tag, input int ntrig);
        int n;
        n = 0;
        while (!data_cmpt && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_cmpt"}, data_cmpt, 1);
`ifdef TC_CAP_CRC_EN
        chk({tag, "_crc"}, cap_crc32, ~crc_m);
`else
        chk({tag, "_crc"}, cap_crc32, 0);
`endif
        chk({tag, "_sb_left"}, exp_q.size(), 0);
        chk({tag, "_ntrig"}, trig_cnt - trig0, ntrig);
        tick();
        chk({tag, "_ncmpt"}, cmpt_cnt - cmpt0, 1);
        chk({tag, "_idle"}, cap_busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cmpt"}, data_cmpt, 0);
        chk({tag, "_busy"}, cap_busy, 0);
        chk({tag, "_err"}, cap_err, 0);
        chk({tag, "_crc"}, cap_crc32, 0);
        chk({tag, "_trig"}, Gc_cap_trig, 0);
        chk({tag, "_datr"}, Gc_mereg_datr, 0);
        chk({tag, "_txen"}, acp0_tx_en, 0);
        chk({tag, "_awaddr"}, acp0_tx_awaddr, 0);
        chk({tag, "_awid"}, acp0_tx_awid, 0);
        chk({tag, "_awlen"}, acp0_tx_awlen, 0);
        chk({tag, "_wdata"}, acp0_tx_wdata, 0);
    endtask

    initial begin
        int n;
        rst = 1;
        data_en = 0;
        cap_points = '0;
        cap_ch_mask = '0;
        cap_addr = '0;
        Gc_capr_rdy = 1;
        repeat (3) tick();
        chk_zero("reset");
        @(posedge clk125);
        #2 rst = 0;

        // Rejected starts: zero points, then zero mask.
        tick();
        trig0 = trig_cnt;
        cap_points = '0;
        cap_ch_mask = 4'b0001;
        data_en = 1;
        tick();
        data_en = 0;
        chk("rej0_cmpt", data_cmpt, 1);
        chk("rej0_err", cap_err, 1);
        chk("rej0_busy", cap_busy, 0);
        tick();
        chk("rej0_cmpt_end", data_cmpt, 0);
        cap_points = 14'd5;
        cap_ch_mask = '0;
        data_en = 1;
        tick();
        data_en = 0;
        chk("rejm_cmpt", data_cmpt, 1);
        tick();
        chk("rej_ntrig", trig_cnt - trig0, 0);
        chk("rej_err_sticky", cap_err, 1);

        // One channel, two bursts.
        start_cap(20, 4'b0001, 32'h1000_0000);
        chk("t1_err_clr", cap_err, 0);
        wait_cmpt("t1", 1);
        chk("t1_nburst", hdr_addr_q.size(), 2);
        chk("t1_a0", hdr_addr_q[0], 32'h1000_0000);
        chk("t1_l0", hdr_len_q[0], 15);
        chk("t1_a1", hdr_addr_q[1], 32'h1000_0080);
        chk("t1_l1", hdr_len_q[1], 3);
        chk("t1_id1", hdr_id_q[1], 0);

        // Two channels, contiguous regions.
        start_cap(16, 4'b1010, 32'h2000_0000);
        wait_cmpt("t2", 2);
        chk("t2_nburst", hdr_addr_q.size(), 2);
        chk("t2_id0", hdr_id_q[0], 1);
        chk("t2_a1", hdr_addr_q[1], 32'h2000_0080);
        chk("t2_id1", hdr_id_q[1], 3);

        // Address wrap across 4 GB.
        start_cap(12, 4'b0101, 32'hFFFF_FFE0);
        wait_cmpt("wrap", 2);
        chk("wrap_a0", hdr_addr_q[0], 32'hFFFF_FFE0);
        chk("wrap_l0", hdr_len_q[0], 11);
        chk("wrap_a1", hdr_addr_q[1], 32'h0000_0040);
        chk("wrap_id1", hdr_id_q[1], 2);

        // Front end not ready for 50 cycles.
        Gc_capr_rdy = 0;
        start_cap(4, 4'b0001, 32'h5000_0000);
        repeat (50) tick();
        chk("arm_notrig", trig_cnt - trig0, 0);
        chk("arm_busy", cap_busy, 1);
        Gc_capr_rdy = 1;
        tick();
        chk("arm_trig", Gc_cap_trig, 1);
        tick();
        chk("arm_trig_pulse", Gc_cap_trig, 0);
        wait_cmpt("arm", 1);

        // Sink stalled: FIFO fills and backpressures.
        sink_hold = 1;
        start_cap(64, 4'b0001, 32'h4000_0000);
        repeat (200) tick();
        chk("full_acc", acc_cnt - acc0, 32);
        chk("full_datr", Gc_mereg_datr, 0);
        sink_hold = 0;
        wait_cmpt("full", 1);

        // Reset in the middle of RECV, then a normal short capture.
        sink_hold = 1;
        start_cap(40, 4'b0001, 32'h6000_0000);
        n = 0;
        while (acc_cnt - acc0 < 8 && n < 500) begin
            tick();
            n++;
        end
        chk("mid_acc", acc_cnt - acc0 >= 8, 1);
        rst = 1;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        acc_pending = 0;
        src_on = 0;
        Gc_mereg_datv = 0;
        s_st = 0;
        req_left = 0;
        beat_pending = 0;
        acp0_tx_rdy = 0;
        acp0_tx_wdreq = 0;
        sink_hold = 0;
        cmpt0 = cmpt_cnt;
        @(posedge clk125);
        #2 rst = 0;
        repeat (5) tick();
        chk("midrst_nocmpt", cmpt_cnt - cmpt0, 0);
        start_cap(4, 4'b0001, 32'h3000_0005);
        wait_cmpt("post", 1);
        chk("post_a0", hdr_addr_q[0], 32'h3000_0000);
        chk("post_l0", hdr_len_q[0], 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
